// File: rtl/cpu_port_mapper.sv
// cpu_port_mapper
//  Sits between input_arbiter and output_queues. Rewrites the destination
//  field of each IOQ module header from the ingress port (MAC 2k <-> CPU 2k+1)
//  and buffers words in a small FIFO so out_rdy backpressure reaches in_rdy.
//  Optional build macro: CPU_PORT_MAPPER_STATS_EN adds pkt_cnt / drop_cnt.
module cpu_port_mapper #(
    parameter int         DATA_WIDTH        = 64,
    parameter int         CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int         NUM_OUTPUT_QUEUES = 8,
    parameter logic [7:0] IOQ_STAGE_NUM     = 8'hff,
    parameter int         FIFO_DEPTH_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  overflow
`ifdef CPU_PORT_MAPPER_STATS_EN
    ,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           drop_cnt
`endif
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CNT_W = FIFO_DEPTH_BITS + 1;
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL      = CTRL_WIDTH'(IOQ_STAGE_NUM);
    localparam logic [CNT_W-1:0]      CNT_EMPTY     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_RDY_LIMIT = CNT_W'(DEPTH - 1);
    localparam logic [15:0]           NUM_PORTS     = 16'(NUM_OUTPUT_QUEUES);

    typedef enum logic [0:0] {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    // Partner port of p (flip bit 0) as a one-hot mask; out-of-range ports map to no queue.
    function automatic logic [15:0] map_dst(input logic [15:0] port);
        logic [15:0] dst;
        if (port < NUM_PORTS) begin
            dst = 16'h0001 << (port ^ 16'h0001);
        end else begin
            dst = 16'h0000;
        end
        return dst;
    endfunction

    state_t                 state_r;
    logic [WORD_W-1:0]      mem_r [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic                   overflow_r;
    logic                   in_rdy_r;

    logic                   is_ioq_s;
    logic [DATA_WIDTH-1:0]  wr_data_s;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   rd_en_s;
    logic                   wr_en_s;
    logic                   lost_s;
    logic [CNT_W-1:0]       count_next_s;

    // Header detection and destination rewrite ahead of the FIFO write.
    always_comb begin
        is_ioq_s  = in_wr && (state_r == ST_HDR) && (in_ctrl == IOQ_CTRL);
        wr_data_s = in_data;
        if (is_ioq_s) begin
            wr_data_s[63:48] = map_dst(in_data[31:16]);
        end else begin
            wr_data_s[63:48] = in_data[63:48];
        end
    end

    // FIFO handshake: a read frees a slot, so a full FIFO still accepts a word while draining.
    always_comb begin
        fifo_empty_s = (count_r == CNT_EMPTY);
        fifo_full_s  = (count_r == CNT_FULL);
        rd_en_s      = reset && !fifo_empty_s && out_rdy;
        wr_en_s      = reset && in_wr && (!fifo_full_s || rd_en_s);
        lost_s       = reset && in_wr && fifo_full_s && !rd_en_s;
        count_next_s = count_r + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
    end

    // Input FSM, FIFO pointers/count, sticky overflow and registered in_rdy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_HDR;
            wr_ptr_r   <= {FIFO_DEPTH_BITS{1'b0}};
            rd_ptr_r   <= {FIFO_DEPTH_BITS{1'b0}};
            count_r    <= CNT_EMPTY;
            overflow_r <= 1'b0;
            in_rdy_r   <= 1'b0;
        end else begin
            if (in_wr) begin
                case (state_r)
                    ST_HDR:     state_r <= (in_ctrl == {CTRL_WIDTH{1'b0}}) ? ST_PAYLOAD : ST_HDR;
                    ST_PAYLOAD: state_r <= (in_ctrl == {CTRL_WIDTH{1'b0}}) ? ST_PAYLOAD : ST_HDR;
                    default:    state_r <= ST_HDR;
                endcase
            end else begin
                state_r <= state_r;
            end
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(FIFO_DEPTH_BITS-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{(FIFO_DEPTH_BITS-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r    <= count_next_s;
            overflow_r <= overflow_r | lost_s;
            in_rdy_r   <= (count_next_s < CNT_RDY_LIMIT);
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {in_ctrl, wr_data_s};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign out_wr               = rd_en_s;
    assign {out_ctrl, out_data} = (reset && !fifo_empty_s) ? mem_r[rd_ptr_r] : {WORD_W{1'b0}};
    assign in_rdy               = in_rdy_r;
    assign overflow             = overflow_r;

`ifdef CPU_PORT_MAPPER_STATS_EN
    logic [31:0] pkt_cnt_r;
    logic [31:0] drop_cnt_r;

    // Count headers that entered the FIFO and headers whose port has no queue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_cnt_r  <= 32'h0000_0000;
            drop_cnt_r <= 32'h0000_0000;
        end else begin
            if (is_ioq_s && wr_en_s) begin
                pkt_cnt_r <= pkt_cnt_r + 32'h0000_0001;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
            if (is_ioq_s && (in_data[31:16] >= NUM_PORTS)) begin
                drop_cnt_r <= drop_cnt_r + 32'h0000_0001;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_r;
    assign drop_cnt = drop_cnt_r;
`endif
endmodule

// File: tb/tb_cpu_port_mapper.sv
// Testbench for cpu_port_mapper: directed literal checks plus a randomized
// packet stream compared every cycle against a queue-based reference model.
module tb_cpu_port_mapper;
    logic        clk = 1'b1;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        overflow;
`ifdef CPU_PORT_MAPPER_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_port_mapper dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .overflow (overflow)
`ifdef CPU_PORT_MAPPER_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [71:0] q[$];
    logic        m_in_hdr;
    logic        m_ovf;
    logic        m_rdy;
    logic        m_valid = 1'b0;
    logic [31:0] m_pkt;
    logic [31:0] m_drop;
    logic        exp_wr;
    logic [71:0] w_in;
    logic [71:0] popped;

    // Expected word after the header rule: dst becomes the partner port's one-hot bit.
    function automatic logic [63:0] expect_word(input logic [63:0] d);
        int p;
        int partner;
        p = int'(d[31:16]);
        if (p >= 8) begin
            d[63:48] = 16'h0000;
        end else begin
            partner  = (p % 2 == 0) ? p + 1 : p - 1;
            d[63:48] = 16'(1 << partner);
        end
        return d;
    endfunction

    // Compare outputs against the model, then advance the model by one clock.
    always @(negedge clk) begin
        if (m_valid) begin
            exp_wr = reset && (q.size() > 0) && out_rdy;
            check("out_wr", 72'(out_wr), 72'(exp_wr));
            if (exp_wr) check("out_word", {out_ctrl, out_data}, q[0]);
            if (!reset) check("out_word_in_reset", {out_ctrl, out_data}, 72'h0);
            check("overflow", 72'(overflow), 72'(m_ovf));
            check("in_rdy", 72'(in_rdy), 72'(m_rdy));
`ifdef CPU_PORT_MAPPER_STATS_EN
            check("pkt_cnt", 72'(pkt_cnt), 72'(m_pkt));
            check("drop_cnt", 72'(drop_cnt), 72'(m_drop));
`endif
        end
        if (!reset) begin
            q.delete();
            m_in_hdr = 1'b1;
            m_ovf    = 1'b0;
            m_rdy    = 1'b0;
            m_pkt    = 32'd0;
            m_drop   = 32'd0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (q.size() > 0 && out_rdy) popped = q.pop_front();
            if (in_wr) begin
                w_in = {in_ctrl, in_data};
                if (m_in_hdr && in_ctrl == 8'hff) begin
                    w_in[63:0] = expect_word(in_data);
                    if (in_data[31:16] >= 16'd8) m_drop = m_drop + 32'd1;
                    if (q.size() < 4) m_pkt = m_pkt + 32'd1;
                end
                if (q.size() < 4) q.push_back(w_in);
                else m_ovf = 1'b1;
                if (m_in_hdr) m_in_hdr = (in_ctrl != 8'h00);
                else m_in_hdr = (in_ctrl != 8'h00);
            end
            m_rdy = (q.size() < 3);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic wr, input logic [7:0] c, input logic [63:0] d, input logic ordy);
        in_wr   = wr;
        in_ctrl = c;
        in_data = d;
        out_rdy = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 64'h0, ordy);
    endtask

    logic [71:0] pend[$];

    task automatic build_pkt();
        logic [15:0] src;
        int          n;
        src = 16'($urandom_range(0, 11));
        pend.push_back({8'hff, 16'($urandom), 16'h0008, src, 16'h0040});
        if ($urandom_range(0, 1) == 1) pend.push_back({8'h20, $urandom, $urandom});
        n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) pend.push_back({8'h00, $urandom, $urandom});
        pend.push_back({8'(8'h01 << $urandom_range(0, 7)), $urandom, $urandom});
    endtask

    task automatic hdr_check(input logic [15:0] src, input logic [15:0] exp_dst, input string name);
        drive(1'b1, 8'hff, {16'hffff, 16'h0008, src, 16'h0040}, 1'b1);
        in_wr = 1'b0;
        #1;
        check({name, "_wr"}, 72'(out_wr), 72'(1'b1));
        check(name, 72'(out_data[63:48]), 72'(exp_dst));
        check({name, "_rest"}, 72'(out_data[47:0]), 72'({16'h0008, src, 16'h0040}));
    endtask

    logic [71:0] w;
    logic        ordy;

    initial begin
        reset = 1'b0;
        drive(1'b0, 8'h00, 64'h0, 1'b0);
        drive(1'b0, 8'h00, 64'h0, 1'b0);
        check("reset_out_wr", 72'(out_wr), 72'(1'b0));
        check("reset_in_rdy", 72'(in_rdy), 72'(1'b0));
        reset = 1'b1;
        idle(1'b0, 1);
        check("post_reset_in_rdy", 72'(in_rdy), 72'(1'b1));

        // Reset in the middle of a buffered packet.
        drive(1'b1, 8'hff, {16'h0, 16'h0008, 16'h0004, 16'h0040}, 1'b0);
        drive(1'b1, 8'h00, 64'hdead_beef_0000_0001, 1'b0);
        drive(1'b1, 8'h00, 64'hdead_beef_0000_0002, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 64'h0, 1'b1);
            check("midpkt_reset_out_wr", 72'(out_wr), 72'(1'b0));
            check("midpkt_reset_overflow", 72'(overflow), 72'(1'b0));
        end
        reset = 1'b1;
        hdr_check(16'd2, 16'h0008, "after_reset_hdr");
        drive(1'b1, 8'h00, 64'h0123_4567_89ab_cdef, 1'b1);
        drive(1'b1, 8'h04, 64'hfedc_ba98_7654_3210, 1'b1);
        idle(1'b1, 3);

        // Header rewrite cases.
        drive(1'b1, 8'hff, 64'h1234_0040_0000_0200, 1'b1);
        in_wr = 1'b0;
        #1;
        check("src0_dst", 72'(out_data[63:48]), 72'(16'h0002));
        check("src0_rest", 72'(out_data[47:0]), 72'(48'h0040_0000_0200));
        hdr_check(16'd5, 16'h0010, "src5_dst");
        hdr_check(16'd9, 16'h0000, "src9_dst");
        hdr_check(16'd7, 16'h0040, "src7_dst");

        // Header-like words inside a packet are never rewritten.
        drive(1'b1, 8'h00, {16'h0000, 16'h0008, 16'h0000, 16'h0040}, 1'b1);
        in_wr = 1'b0;
        #1;
        check("payload_not_rewritten", {out_ctrl, out_data}, {8'h00, 16'h0000, 16'h0008, 16'h0000, 16'h0040});
        drive(1'b1, 8'hff, {16'h0000, 16'h0008, 16'h0000, 16'h0040}, 1'b1);
        in_wr = 1'b0;
        #1;
        check("eop_not_rewritten", 72'(out_data[63:48]), 72'(16'h0000));
        idle(1'b1, 2);

        // Burst of six with out_rdy low: four kept, overflow sticks.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'h00, 64'h0a00 + 64'(k), 1'b0);
            if (k == 1) check("burst_in_rdy_2", 72'(in_rdy), 72'(1'b1));
            if (k == 2) check("burst_in_rdy_3", 72'(in_rdy), 72'(1'b0));
        end
        in_wr = 1'b0;
        #1;
        check("burst_overflow", 72'(overflow), 72'(1'b1));
        for (int k = 0; k < 4; k++) begin
            out_rdy = 1'b1;
            #1;
            check("burst_order", {out_wr, out_ctrl, out_data[62:0]}, {1'b1, 8'h00, 63'h0a00 + 63'(k)});
            @(posedge clk);
            #1;
        end
        check("burst_empty", 72'(out_wr), 72'(1'b0));

        reset = 1'b0;
        idle(1'b1, 2);
        reset = 1'b1;
        idle(1'b1, 1);

        // Random packet stream honouring in_rdy, out_rdy toggling then random.
        for (int i = 0; i < 600; i++) begin
            ordy = (i < 200) ? i[0] : ($urandom_range(0, 2) != 0);
            if (pend.size() == 0) build_pkt();
            if (in_rdy && $urandom_range(0, 3) != 0) begin
                w = pend.pop_front();
                drive(1'b1, w[71:64], w[63:0], ordy);
            end else begin
                drive(1'b0, 8'h00, 64'h0, ordy);
            end
        end
        // Random stream ignoring in_rdy so overflow and full-FIFO drops occur.
        for (int i = 0; i < 200; i++) begin
            ordy = ($urandom_range(0, 2) == 0);
            if (pend.size() == 0) build_pkt();
            if ($urandom_range(0, 3) != 0) begin
                w = pend.pop_front();
                drive(1'b1, w[71:64], w[63:0], ordy);
            end else begin
                drive(1'b0, 8'h00, 64'h0, ordy);
            end
        end
        idle(1'b1, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
